// File: rtl/slave_port_pkg.sv
// Shared types and constants for the memory-mapped slave port.
//   slave_state_t        : slave FSM states
//   port_transmite_type  : master -> slave command/write-data bundle
//   port_receive_type    : slave -> master read-data/flow-control bundle
//   MAX_BURST / CNT_W    : largest burst length and the beat counter width
//   eff_burst()          : burstcount with 0 mapped to 1
//   lane_mask()          : byte-enable nibble expanded to a 32-bit mask
package slave_port_pkg;

  localparam int MAX_BURST = 15;
  localparam int CNT_W     = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    READ_ISSUE = 2'd2,
    READ_DRAIN = 2'd3
  } slave_state_t;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [3:0]  dataena;
    logic [3:0]  burstcount;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_transmite_type;

  typedef struct packed {
    logic [31:0] rdata;
    logic        valid;
    logic        waitrequest;
  } port_receive_type;

  function automatic logic [3:0] eff_burst(input logic [3:0] bc);
    return (bc == 4'd0) ? 4'd1 : bc;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/slave_port_if.sv
// Master/slave bus bundle for slave_port.
//   master2slave : command, address, byte enables, burst length, write data
//   slave2master : read data, read-data valid, waitrequest
// modport master drives commands; modport slave answers them.
interface slave_port_if;
  import slave_port_pkg::*;

  port_transmite_type master2slave;
  port_receive_type   slave2master;

  modport master (output master2slave, input  slave2master);
  modport slave  (input  master2slave, output slave2master);

endinterface

// File: rtl/slave_port.sv
// Burst-capable slave port in front of a synchronous single-port memory.
// Decodes a 4*2^MEM_AW byte window at BASE_ADDR, streams write beats to the
// memory one cycle after acceptance, and returns read bursts with a fixed
// three-edge latency from the accepting edge.
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-low reset
//   bus        : slave modport (master2slave in, slave2master out)
//   mem_addr   : word address to memory
//   mem_we     : memory write strobe
//   mem_be     : memory byte-lane enables
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, one cycle after mem_addr with mem_we=0
module slave_port
  import slave_port_pkg::*;
#(
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  slave_port_if.slave       bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [32:0] WIN_BYTES = 33'd4 << MEM_AW;

  port_transmite_type m2s;
  assign m2s = bus.master2slave;

  slave_state_t      state_q, state_d;
  logic              wait_q, wait_d;
  logic [MEM_AW-1:0] waddr_q, waddr_d;
  logic [3:0]        be_q, be_d;
  logic              in_range_q, in_range_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // [0]: a read address is on mem_addr this cycle; [1]: mem_rdata holds read data
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic              valid_q, valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Command decode
  logic [31:0]       win_off;
  logic              cmd_in_range;
  logic [MEM_AW-1:0] cmd_waddr;
  logic [3:0]        cmd_burst;

  always_comb begin
    win_off      = m2s.addr - BASE_ADDR;
    cmd_in_range = (m2s.addr >= BASE_ADDR) && ({1'b0, win_off} < WIN_BYTES);
    cmd_waddr    = m2s.addr[MEM_AW+1:2];
    cmd_burst    = eff_burst(m2s.burstcount);
  end

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    be_d        = be_q;
    in_range_d  = in_range_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    vld_pipe_d  = {vld_pipe_q[0], 1'b0};
    // Read return path runs independently of the FSM: one register stage
    // behind mem_rdata, masked by the captured lanes and window hit.
    valid_d     = vld_pipe_q[1];
    rdata_d     = 32'h0;
    if (vld_pipe_q[1] && in_range_q) rdata_d = mem_rdata & lane_mask(be_q);

    unique case (state_q)
      IDLE: begin
        // wait_q is only high here in the first cycle out of reset.
        if (!wait_q && m2s.write) begin
          // Write wins over a simultaneous read; first beat goes out now.
          be_d        = m2s.dataena;
          in_range_d  = cmd_in_range;
          mem_we_d    = cmd_in_range;
          mem_addr_d  = cmd_waddr;
          mem_be_d    = m2s.dataena;
          mem_wdata_d = m2s.wdata;
          waddr_d     = cmd_waddr + MEM_AW'(1);
          cnt_d       = CNT_W'(cmd_burst - 4'd1);
          if (cmd_burst > 4'd1) state_d = WRITE;
        end else if (!wait_q && m2s.read) begin
          be_d       = m2s.dataena;
          in_range_d = cmd_in_range;
          waddr_d    = cmd_waddr;
          cnt_d      = CNT_W'(cmd_burst);
          state_d    = READ_ISSUE;
        end
      end
      WRITE: begin
        // write low is a stall: nothing moves.
        if (m2s.write) begin
          mem_we_d    = in_range_q;
          mem_addr_d  = waddr_q;
          mem_be_d    = be_q;
          mem_wdata_d = m2s.wdata;
          waddr_d     = waddr_q + MEM_AW'(1);
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = IDLE;
        end
      end
      READ_ISSUE: begin
        mem_addr_d    = waddr_q;
        mem_be_d      = be_q;
        vld_pipe_d[0] = 1'b1;
        waddr_d       = waddr_q + MEM_AW'(1);
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = READ_DRAIN;
      end
      READ_DRAIN: begin
        // Leave when the final beat is on the bus and nothing is in flight.
        if (valid_q && (vld_pipe_q == 2'b00)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wait_d = (state_d == READ_ISSUE) || (state_d == READ_DRAIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wait_q      <= 1'b1;
      waddr_q     <= '0;
      be_q        <= '0;
      in_range_q  <= 1'b0;
      cnt_q       <= '0;
      vld_pipe_q  <= '0;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      waddr_q     <= waddr_d;
      be_q        <= be_d;
      in_range_q  <= in_range_d;
      cnt_q       <= cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      valid_q     <= valid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.slave2master = '{rdata: rdata_q, valid: valid_q, waitrequest: wait_q};
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_slave_port.sv
// Scoreboard bench for slave_port: drivers push expected memory writes and
// read beats (value and arrival cycle) into queues; a negedge monitor pops
// and compares whenever mem_we or valid is seen.
module tb_slave_port;
  import slave_port_pkg::*;

  localparam int          AW   = 10;
  localparam int          N    = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  slave_port_if bus_if();

  slave_port #(.MEM_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int nvalid = 0;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) - longint'(BASE) < longint'(4 * N));
  endfunction

  // Synchronous memory attached to the DUT
  logic [31:0] mem [N];
  bit          written [N];

  function automatic logic [31:0] cur_word(input logic [AW-1:0] a);
    return written[a] ? mem[a] : init_val(int'(a));
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= merge(cur_word(mem_addr), mem_wdata, mem_be);
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= cur_word(mem_addr);
  end

  // Reference model: what the memory should hold, updated from stimulus
  logic [31:0] ref_mem [N];

  typedef struct { int cyc; logic [31:0] data; } rexp_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [3:0] be; logic [31:0] data; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t re;
  wexp_t we_e;

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      if (bus_if.slave2master.valid) begin
        nvalid++;
        checks++;
        if (rq.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected rdata=%h cyc=%0d", bus_if.slave2master.rdata, cyc);
        end else begin
          re = rq.pop_front();
          if (bus_if.slave2master.rdata !== re.data || cyc != re.cyc) begin
            failures++;
            $display("FAIL rd_beat got=%h@%0d exp=%h@%0d", bus_if.slave2master.rdata, cyc, re.data, re.cyc);
          end
        end
      end
      if (mem_we) begin
        checks++;
        if (wq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected addr=%0d data=%h cyc=%0d", mem_addr, mem_wdata, cyc);
        end else begin
          we_e = wq.pop_front();
          if (mem_addr !== we_e.addr || mem_be !== we_e.be || mem_wdata !== we_e.data || cyc != we_e.cyc) begin
            failures++;
            $display("FAIL wr_beat got=%0d/%h/%h@%0d exp=%0d/%h/%h@%0d", mem_addr, mem_be, mem_wdata, cyc,
                     we_e.addr, we_e.be, we_e.data, we_e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus_if.master2slave = '0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (bus_if.slave2master.waitrequest && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_ready timeout");
    end
  endtask

  task automatic drain_check();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (rq.size() != 0 || wq.size() != 0) begin
      failures++;
      $display("FAIL drain pending_rd=%0d pending_wr=%0d exp=0", rq.size(), wq.size());
      rq.delete(); wq.delete();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_waitrequest", 32'(bus_if.slave2master.waitrequest), 32'd1);
    chk("rst_valid", 32'(bus_if.slave2master.valid), 32'd0);
    chk("rst_rdata", bus_if.slave2master.rdata, 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_waitrequest", 32'(bus_if.slave2master.waitrequest), 32'd0);
  endtask

  // stall_len < 0: random 0..2 idle cycles before each later beat;
  // otherwise stall_len idle cycles before beat stall_beat only.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input logic [3:0] burst,
                          input bit rd_too, input bit fixed, input logic [31:0] d0,
                          input int stall_beat, input int stall_len);
    int nb, w, stalls;
    bit hit;
    logic [31:0] d;
    nb  = (burst == 0) ? 1 : int'(burst);
    hit = in_win(addr);
    w   = int'(addr[AW+1:2]);
    wait_ready();
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        if (stall_len < 0) stalls = $urandom_range(0, 2);
        else stalls = (i == stall_beat) ? stall_len : 0;
        repeat (stalls) begin
          bus_if.master2slave.write = 1'b0;
          bus_if.master2slave.read  = 1'b0;
          @(negedge clk);
        end
      end
      d = fixed ? d0 + 32'(i) : $urandom;
      bus_if.master2slave.write      = 1'b1;
      bus_if.master2slave.read       = (i == 0) && rd_too;
      bus_if.master2slave.dataena    = be;
      bus_if.master2slave.burstcount = burst;
      bus_if.master2slave.addr       = addr;
      bus_if.master2slave.wdata      = d;
      if (hit) begin
        wq.push_back('{cyc + 1, AW'((w + i) % N), be, d});
        ref_mem[(w + i) % N] = merge(ref_mem[(w + i) % N], d, be);
      end
      @(negedge clk);
    end
    idle_bus();
    chk("wr_waitrequest_low", 32'(bus_if.slave2master.waitrequest), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] be, input logic [3:0] burst);
    int nb, w, a, n;
    bit hit;
    nb  = (burst == 0) ? 1 : int'(burst);
    hit = in_win(addr);
    w   = int'(addr[AW+1:2]);
    wait_ready();
    bus_if.master2slave.read       = 1'b1;
    bus_if.master2slave.write      = 1'b0;
    bus_if.master2slave.dataena    = be;
    bus_if.master2slave.burstcount = burst;
    bus_if.master2slave.addr       = addr;
    a = cyc + 1;
    for (int i = 0; i < nb; i++)
      rq.push_back('{a + 3 + i, hit ? merge(32'h0, ref_mem[(w + i) % N], be) : 32'h0});
    @(negedge clk);
    idle_bus();
    chk("rd_waitrequest_high", 32'(bus_if.slave2master.waitrequest), 32'd1);
    n = 0;
    while (bus_if.slave2master.waitrequest && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_waitrequest_fall_cycle", 32'(cyc), 32'(a + nb + 3));
  endtask

  initial begin
    int base, n;
    logic [31:0] ra;
    for (int i = 0; i < N; i++) ref_mem[i] = init_val(i);
    idle_bus();
    do_reset();

    // Single write, then a 4-word block for the burst read
    do_write(32'h08, 4'hF, 4'd1, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 0);
    do_write(32'h10, 4'hF, 4'd4, 1'b0, 1'b1, 32'd1, 0, 0);
    drain_check();
    do_read(32'h10, 4'hF, 4'd4);
    drain_check();
    chk("ref_block_word4", ref_mem[4], 32'd1);
    do_read(32'h08, 4'h3, 4'd1);
    drain_check();

    // 3-beat write with write dropped 2 cycles before beat 2, read back
    do_write(32'h40, 4'hF, 4'd3, 1'b0, 1'b0, 32'h0, 2, 2);
    drain_check();
    do_read(32'h40, 4'hF, 4'd3);
    drain_check();

    // Word-address wrap at the top of the memory
    do_write(32'hFF8, 4'hA, 4'd4, 1'b0, 1'b0, 32'h0, 0, 0);
    drain_check();
    do_read(32'hFF8, 4'hF, 4'd4);
    drain_check();

    // Just outside the window: no mem_we, reads return zero
    do_write(BASE + 32'(4 * N), 4'hF, 4'd2, 1'b0, 1'b0, 32'h0, 0, 0);
    drain_check();
    do_read(BASE + 32'(4 * N), 4'hF, 4'd1);
    drain_check();

    // burstcount 0 behaves as 1; maximum burst; write+read together
    do_write(32'h100, 4'h5, 4'd0, 1'b0, 1'b0, 32'h0, 0, 0);
    do_read(32'h100, 4'hF, 4'd0);
    drain_check();
    do_read(32'h200, 4'hC, 4'd15);
    drain_check();
    do_write(32'h300, 4'hF, 4'd2, 1'b1, 1'b0, 32'h0, 0, 0);
    drain_check();
    do_read(32'h300, 4'hF, 4'd2);
    drain_check();

    // Reset during a 4-beat read after two valid beats
    base = nvalid;
    wait_ready();
    bus_if.master2slave.read       = 1'b1;
    bus_if.master2slave.dataena    = 4'hF;
    bus_if.master2slave.burstcount = 4'd4;
    bus_if.master2slave.addr       = 32'h10;
    for (int i = 0; i < 4; i++) rq.push_back('{cyc + 4 + i, ref_mem[4 + i]});
    @(negedge clk);
    idle_bus();
    n = 0;
    while (nvalid < base + 2 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_two_valids_seen", 32'(nvalid - base), 32'd2);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(bus_if.slave2master.valid), 32'd0);
    chk("abort_waitrequest", 32'(bus_if.slave2master.waitrequest), 32'd1);
    rq.delete();
    do_reset();
    repeat (4) @(negedge clk);
    chk("abort_no_more_valids", 32'(nvalid - base), 32'd2);
    do_read(32'h10, 4'hF, 4'd1);
    drain_check();

    // Randomized mix
    for (int k = 0; k < 40; k++) begin
      ra = $urandom_range(0, 4 * N + 256);
      if ($urandom_range(0, 1) == 1)
        do_write(ra, 4'($urandom), 4'($urandom), $urandom_range(0, 3) == 0, 1'b0, 32'h0, 0, -1);
      else
        do_read(ra, 4'($urandom), 4'($urandom));
      drain_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
